// File: rtl/mdu_iterative.sv
// Iterative unsigned multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock, with a single registered write-back cycle to the register file.
module mdu_iterative #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned ITER  = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       Dest,
   output logic             Busy,
   output logic             Stall,
   output logic             RegWre,
   output logic [3:0]       WriteReg,
   output logic [WIDTH-1:0] WriteData,
   output logic             Done,
   output logic             DivZero
);

   localparam int unsigned CW = $clog2(ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [1:0]         op_q, op_d;
   logic [3:0]         dest_q, dest_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic               regwre_q, regwre_d;
   logic [3:0]         wreg_q, wreg_d;
   logic [WIDTH-1:0]   wdata_q, wdata_d;
   logic               done_q, done_d;
   logic               divzero_q, divzero_d;

   logic [2*WIDTH-1:0] addend;
   logic [CW-1:0]      dvd_idx;
   logic [WIDTH:0]     rem_sh;
   logic               no_borrow;
   logic               div_by_zero;
   logic [WIDTH-1:0]   result;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      dest_d    = dest_q;
      prod_d    = prod_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      regwre_d  = regwre_q;
      wreg_d    = wreg_q;
      wdata_d   = wdata_q;
      done_d    = done_q;
      divzero_d = divzero_q;

      addend      = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
      dvd_idx     = CW'(WIDTH - 1) - cnt_q;
      rem_sh      = {rem_q, a_q[dvd_idx]};
      // Partial remainder never exceeds the divisor, so the low WIDTH bits of the difference are exact.
      no_borrow   = (rem_sh >= {1'b0, b_q});
      div_by_zero = (b_q == '0);
      result      = '0;

      case (state_q)
         IDLE: begin
            if (Start) begin
               a_d     = A;
               b_d     = B;
               op_d    = Op;
               dest_d  = Dest;
               prod_d  = '0;
               rem_d   = '0;
               quo_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            prod_d = prod_q + addend;
            rem_d  = no_borrow ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
            quo_d  = {quo_q[WIDTH-2:0], no_borrow};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(ITER - 1)) begin
               case (op_q)
                  2'b00:   result = prod_d[WIDTH-1:0];
                  2'b01:   result = prod_d[2*WIDTH-1:WIDTH];
                  2'b10:   result = div_by_zero ? '1 : quo_d;
                  default: result = div_by_zero ? a_q : rem_d;
               endcase
               wdata_d   = result;
               wreg_d    = dest_q;
               regwre_d  = (dest_q != 4'd0);
               done_d    = 1'b1;
               divzero_d = op_q[1] & div_by_zero;
               state_d   = WB;
            end
         end
         WB: begin
            regwre_d  = 1'b0;
            done_d    = 1'b0;
            divzero_d = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         dest_q    <= '0;
         prod_q    <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         regwre_q  <= 1'b0;
         wreg_q    <= '0;
         wdata_q   <= '0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         dest_q    <= dest_d;
         prod_q    <= prod_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         regwre_q  <= regwre_d;
         wreg_q    <= wreg_d;
         wdata_q   <= wdata_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
      end
   end

   assign Busy      = (state_q != IDLE);
   assign Stall     = Busy | (Start & (state_q == IDLE));
   assign RegWre    = regwre_q;
   assign WriteReg  = wreg_q;
   assign WriteData = wdata_q;
   assign Done      = done_q;
   assign DivZero   = divzero_q;

endmodule
